// File: rtl/vend_controller.sv
// Vending controller: checks credit against the selected item's price, dispenses the item,
// pays change largest coin first, then pulses a clear to the coin counter.
module vend_controller #(
    parameter logic [9:0] PRICE0        = 10'd50,
    parameter logic [9:0] PRICE1        = 10'd65,
    parameter logic [9:0] PRICE2        = 10'd75,
    parameter logic [9:0] PRICE3        = 10'd100,
    parameter logic [9:0] QUARTER_VALUE = 10'd25,
    parameter logic [9:0] DIME_VALUE    = 10'd10,
    parameter logic [9:0] NICKEL_VALUE  = 10'd5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] moneyCount,
    input  logic [1:0] sel,
    input  logic       buy,
    input  logic       cancel,
    output logic       dispense,
    output logic [1:0] item,
    output logic       outQ,
    output logic       outD,
    output logic       outN,
    output logic       countClr,
    output logic       coinInhibit,
    output logic       lowFunds
);

    typedef enum logic [1:0] {IDLE, VEND, CHANGE, CLEAR} state_t;

    state_t     state_q, state_d;
    logic [9:0] rem_q, rem_d;
    logic [1:0] item_q, item_d;
    logic [9:0] price;
    logic       dispense_q, dispense_d;
    logic       quarter_q, quarter_d;
    logic       dime_q, dime_d;
    logic       nickel_q, nickel_d;
    logic       clr_q, clr_d;
    logic       inhibit_q, inhibit_d;
    logic       low_q, low_d;

    always_comb begin
        case (sel)
            2'd0:    price = PRICE0;
            2'd1:    price = PRICE1;
            2'd2:    price = PRICE2;
            default: price = PRICE3;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        item_d  = item_q;
        low_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cancel) begin
                    rem_d   = moneyCount;
                    state_d = (moneyCount >= NICKEL_VALUE) ? CHANGE : CLEAR;
                end else if (buy) begin
                    if (moneyCount >= price) begin
                        rem_d   = moneyCount - price;
                        item_d  = sel;
                        state_d = VEND;
                    end else begin
                        low_d = 1'b1;
                    end
                end
            end
            VEND: begin
                state_d = (rem_q >= NICKEL_VALUE) ? CHANGE : CLEAR;
            end
            CHANGE: begin
                // CHANGE is only entered with rem >= 5, so the nickel step cannot underflow.
                if (rem_q >= QUARTER_VALUE) begin
                    rem_d = rem_q - QUARTER_VALUE;
                end else if (rem_q >= DIME_VALUE) begin
                    rem_d = rem_q - DIME_VALUE;
                end else begin
                    rem_d = rem_q - NICKEL_VALUE;
                end
                state_d = (rem_d >= NICKEL_VALUE) ? CHANGE : CLEAR;
            end
            CLEAR: begin
                rem_d   = 10'd0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pulses are decoded from the next state so they appear registered in the cycle
    // the FSM actually occupies that state; the coin choice uses the value CHANGE will see.
    always_comb begin
        dispense_d = (state_d == VEND);
        quarter_d  = (state_d == CHANGE) && (rem_d >= QUARTER_VALUE);
        dime_d     = (state_d == CHANGE) && (rem_d < QUARTER_VALUE) && (rem_d >= DIME_VALUE);
        nickel_d   = (state_d == CHANGE) && (rem_d < DIME_VALUE);
        clr_d      = (state_d == CLEAR);
        inhibit_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            rem_q      <= 10'd0;
            item_q     <= 2'd0;
            dispense_q <= 1'b0;
            quarter_q  <= 1'b0;
            dime_q     <= 1'b0;
            nickel_q   <= 1'b0;
            clr_q      <= 1'b0;
            inhibit_q  <= 1'b0;
            low_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            item_q     <= item_d;
            dispense_q <= dispense_d;
            quarter_q  <= quarter_d;
            dime_q     <= dime_d;
            nickel_q   <= nickel_d;
            clr_q      <= clr_d;
            inhibit_q  <= inhibit_d;
            low_q      <= low_d;
        end
    end

    assign dispense    = dispense_q;
    assign item        = item_q;
    assign outQ        = quarter_q;
    assign outD        = dime_q;
    assign outN        = nickel_q;
    assign countClr    = clr_q;
    assign coinInhibit = inhibit_q;
    assign lowFunds    = low_q;

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: stimulus queues hand-computed output events with
// their cycle stamps, and a monitor pops and compares them as the DUT presents pulses.
module tb_vend_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] moneyCount = 10'd0;
    logic [1:0] sel = 2'd0;
    logic       buy = 1'b0;
    logic       cancel = 1'b0;
    logic       dispense;
    logic [1:0] item;
    logic       outQ, outD, outN, countClr, coinInhibit, lowFunds;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int base = 0;
    logic monitorOn = 1'b0;

    // Event vector layout: {dispense, item[1:0], outQ, outD, outN, countClr, lowFunds, coinInhibit}
    localparam logic [8:0] EV_Q    = 9'b0_00_1_0_0_0_0_1;
    localparam logic [8:0] EV_D    = 9'b0_00_0_1_0_0_0_1;
    localparam logic [8:0] EV_N    = 9'b0_00_0_0_1_0_0_1;
    localparam logic [8:0] EV_CLR  = 9'b0_00_0_0_0_1_0_1;
    localparam logic [8:0] EV_LOW  = 9'b0_00_0_0_0_0_1_0;
    localparam logic [8:0] ALL_LOW = 9'b0_00_0_0_0_0_0_0;

    typedef struct {
        int         cyc;
        logic [8:0] vec;
    } exp_t;

    exp_t sbq[$];

    vend_controller dut (
        .clk        (clk),
        .rst        (rst),
        .moneyCount (moneyCount),
        .sel        (sel),
        .buy        (buy),
        .cancel     (cancel),
        .dispense   (dispense),
        .item       (item),
        .outQ       (outQ),
        .outD       (outD),
        .outN       (outN),
        .countClr   (countClr),
        .coinInhibit(coinInhibit),
        .lowFunds   (lowFunds)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [8:0] evDisp(input logic [1:0] it);
        return {1'b1, it, 6'b000001};
    endfunction

    task automatic expectAt(input int off, input logic [8:0] v);
        exp_t e;
        e.cyc = base + off;
        e.vec = v;
        sbq.push_back(e);
    endtask

    task automatic expectRun(input int first, input int count, input logic [8:0] v);
        for (int i = 0; i < count; i++) expectAt(first + i, v);
    endtask

    // Drives one request for a single cycle; base marks the cycle whose closing edge samples it.
    task automatic applyStimulus(input logic [9:0] m, input logic [1:0] s,
                                 input logic b, input logic c);
        @(negedge clk);
        moneyCount = m;
        sel        = s;
        buy        = b;
        cancel     = c;
        base       = cyc;
    endtask

    task automatic releaseRequest();
        @(negedge clk);
        buy    = 1'b0;
        cancel = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [8:0] got, input logic [8:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b", name, got, want);
        end
    endtask

    function automatic logic [8:0] rawOutputs();
        return {dispense, item, outQ, outD, outN, countClr, lowFunds, coinInhibit};
    endfunction

    always @(negedge clk) begin
        logic [8:0] act;
        logic       isEvent;
        exp_t       e;
        if (monitorOn && rst) begin
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                e = sbq.pop_front();
                checks++;
                failures++;
                $display("[TB] FAIL missed_event: got none at cycle %0d expected %b", e.cyc, e.vec);
            end
            act     = {dispense, (dispense ? item : 2'b00), outQ, outD, outN, countClr, lowFunds, coinInhibit};
            isEvent = dispense | outQ | outD | outN | countClr | lowFunds;
            checks++;
            if (isEvent) begin
                if (sbq.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_event: got %b at cycle %0d expected none", act, cyc);
                end else begin
                    e = sbq.pop_front();
                    if (e.cyc != cyc || e.vec !== act) begin
                        failures++;
                        $display("[TB] FAIL event: got %b at cycle %0d expected %b at cycle %0d",
                                 act, cyc, e.vec, e.cyc);
                    end
                end
            end else if (coinInhibit !== 1'b0) begin
                failures++;
                $display("[TB] FAIL idle_inhibit: got %b at cycle %0d expected 0", coinInhibit, cyc);
            end
        end
    end

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", rawOutputs(), ALL_LOW);
        rst = 1'b1;
        monitorOn = 1'b1;
        idleCycles(2);

        // Exact payment: 50 for item 0, no change.
        applyStimulus(10'd50, 2'd0, 1'b1, 1'b0);
        expectAt(1, evDisp(2'd0));
        expectAt(2, EV_CLR);
        releaseRequest();
        idleCycles(4);

        // 100 for item 1 leaves 35: quarter then dime.
        applyStimulus(10'd100, 2'd1, 1'b1, 1'b0);
        expectAt(1, evDisp(2'd1));
        expectAt(2, EV_Q);
        expectAt(3, EV_D);
        expectAt(4, EV_CLR);
        releaseRequest();
        idleCycles(6);

        // 70 is short of 75: refused.
        applyStimulus(10'd70, 2'd2, 1'b1, 1'b0);
        expectAt(1, EV_LOW);
        releaseRequest();
        idleCycles(4);

        // Cancel beats buy: 40 refunded as quarter, dime, nickel.
        applyStimulus(10'd40, 2'd0, 1'b1, 1'b1);
        expectAt(1, EV_Q);
        expectAt(2, EV_D);
        expectAt(3, EV_N);
        expectAt(4, EV_CLR);
        releaseRequest();
        idleCycles(6);

        // 52 for item 0 leaves 2 cents, discarded without a coin.
        applyStimulus(10'd52, 2'd0, 1'b1, 1'b0);
        expectAt(1, evDisp(2'd0));
        expectAt(2, EV_CLR);
        releaseRequest();
        idleCycles(4);

        // Maximum credit 1023 for item 3 leaves 923: 36 quarters, 2 dimes, 3 cents dropped.
        applyStimulus(10'd1023, 2'd3, 1'b1, 1'b0);
        expectAt(1, evDisp(2'd3));
        expectRun(2, 36, EV_Q);
        expectRun(38, 2, EV_D);
        expectAt(40, EV_CLR);
        releaseRequest();
        idleCycles(42);

        // Reset during the first quarter of a 50-cent change run.
        applyStimulus(10'd100, 2'd0, 1'b1, 1'b0);
        expectAt(1, evDisp(2'd0));
        expectAt(2, EV_Q);
        releaseRequest();
        @(negedge clk);
        #1 rst = 1'b0;
        #1 checkOutput("async_reset_outputs", rawOutputs(), ALL_LOW);
        idleCycles(2);
        rst = 1'b1;
        idleCycles(6);
        checkOutput("after_reset_idle", rawOutputs(), ALL_LOW);

        // Zero credit cancel goes straight to the clear.
        applyStimulus(10'd0, 2'd0, 1'b0, 1'b1);
        expectAt(1, EV_CLR);
        releaseRequest();
        idleCycles(3);

        // 100-cent refund with buy and moneyCount churned during CHANGE.
        applyStimulus(10'd100, 2'd0, 1'b0, 1'b1);
        expectRun(1, 4, EV_Q);
        expectAt(5, EV_CLR);
        releaseRequest();
        buy        = 1'b1;
        moneyCount = 10'd1023;
        sel        = 2'd3;
        idleCycles(2);
        buy        = 1'b0;
        moneyCount = 10'd0;
        idleCycles(6);

        for (int i = 0; i < 100 && sbq.size() > 0; i++) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
